// File: rtl/booth_pkg.sv
// Shared types and defaults for the sequential radix-4 Booth multiplier.
package booth_pkg;

   // Default operand width. The width must be even and at least 4.
   localparam int BOOTH_N_BITS = 8;

   // Control states of the iterative multiplier.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Booth digit encoding of one 3-bit multiplier window:
   // s selects 1*a, d selects 2*a, n negates (one's complement, +1 added later).
   typedef struct packed {
      logic s;
      logic d;
      logic n;
   } booth_enc_t;

endpackage

// File: rtl/booth_window_enc.sv
// Radix-4 Booth window encoder: maps bits (b[2i+1], b[2i], b[2i-1]) to s/d/n.
module booth_window_enc
   import booth_pkg::*;
(
   input  logic [2:0] win_i,
   output booth_enc_t enc_o
);

   // Pure decode of the window; the window 111 yields n=1 with s=d=0,
   // which the accumulator turns into a zero contribution (~0 + 1).
   always_comb begin
      enc_o.s = win_i[1] ^ win_i[0];
      enc_o.d = (win_i[2] & ~win_i[1] & ~win_i[0]) |
                (~win_i[2] & win_i[1] & win_i[0]);
      enc_o.n = win_i[2];
   end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Iterative signed radix-4 Booth multiplier, one Booth window per cycle.
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high. in_ready is high only in IDLE; out_valid is high only
// in DONE, and product is stable while out_valid is high and out_ready is low.
module booth_seq_multiplier
   import booth_pkg::*;
#(
   parameter int N_BITS = BOOTH_N_BITS
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [N_BITS-1:0]     a,
   input  logic [N_BITS-1:0]     b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [2*N_BITS-1:0]   product,
   output logic                  booth_s,
   output logic                  booth_d,
   output logic                  booth_n
);

   localparam int ITER = N_BITS / 2;
   localparam int PW   = 2 * N_BITS;
   localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(ITER - 1);

   state_t              state_q;
   logic [N_BITS-1:0]   a_q;
   logic [N_BITS-1:0]   mult_q;      // multiplier, shifted right two bits per window
   logic                prev_q;      // b[2i-1] for the current window
   logic [PW-1:0]       acc_q;
   logic [PW-1:0]       product_q;
   logic [CW-1:0]       cnt_q;
   logic                in_ready_q;
   logic                out_valid_q;

   logic [2:0]          win;
   booth_enc_t          enc;
   logic [N_BITS+1:0]   a_ext;       // {sign, a, a[-1]=0}
   logic [N_BITS:0]     pp;
   logic [PW-1:0]       term_d;
   logic [PW-1:0]       acc_d;

   assign win   = {mult_q[1:0], prev_q};
   assign a_ext = {a_q[N_BITS-1], a_q, 1'b0};

   booth_window_enc u_enc (
      .win_i (win),
      .enc_o (enc)
   );

   // Partial product for the current window, then sign-extend, add the
   // negation carry and weight it by 4^i before accumulating.
   always_comb begin
      pp = '0;
      for (int j = 0; j <= N_BITS; j++) begin
         pp[j] = ((enc.s & a_ext[j+1]) | (enc.d & a_ext[j])) ^ enc.n;
      end
      term_d = {{(PW-N_BITS-1){pp[N_BITS]}}, pp} + PW'(enc.n);
      acc_d  = acc_q + (term_d << {cnt_q, 1'b0});
   end

   // Control FSM with datapath registers; reset overrides every transition.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         a_q         <= '0;
         mult_q      <= '0;
         prev_q      <= 1'b0;
         acc_q       <= '0;
         product_q   <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  a_q        <= a;
                  mult_q     <= b;
                  prev_q     <= 1'b0;
                  acc_q      <= '0;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= BUSY;
               end
            end
            BUSY: begin
               acc_q  <= acc_d;
               mult_q <= mult_q >> 2;
               prev_q <= mult_q[1];
               if (cnt_q == LAST_CNT) begin
                  cnt_q       <= '0;
                  product_q   <= acc_d;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               // in_ready rises only after leaving DONE, so no accept
               // coincides with the result handshake.
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Window encoding is only meaningful while a window is being accumulated.
   always_comb begin
      booth_s = (state_q == BUSY) & enc.s;
      booth_d = (state_q == BUSY) & enc.d;
      booth_n = (state_q == BUSY) & enc.n;
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign product   = product_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Self-checking bench for booth_seq_multiplier: directed corner cases,
// reset-in-flight cases and randomized operands against an arithmetic model.
module tb_booth_seq_multiplier;
  import booth_pkg::*;

  localparam int N    = BOOTH_N_BITS;
  localparam int ITER = N / 2;
  localparam int PW   = 2 * N;
  localparam int N_RANDOM = 3000;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] product;
  logic          booth_s;
  logic          booth_d;
  logic          booth_n;

  int n_checks = 0;
  int n_pass   = 0;
  logic [PW-1:0] exp_q[$];

  booth_seq_multiplier #(.N_BITS(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .booth_s   (booth_s),
    .booth_d   (booth_d),
    .booth_n   (booth_n)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: plain signed multiplication, truncated to the product width.
  function automatic logic [PW-1:0] model_product(input logic [N-1:0] x, input logic [N-1:0] y);
    longint sx;
    longint sy;
    longint p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p  = sx * sy;
    return p[PW-1:0];
  endfunction

  // Reference window encoding from the Booth digit value -2*b[2i+1]+b[2i]+b[2i-1].
  function automatic logic [2:0] model_window(input logic [N-1:0] y, input int i);
    logic [N:0] yx;
    int hi;
    int mid;
    int lo;
    int digit;
    logic s;
    logic d;
    yx    = {y, 1'b0};
    hi    = int'(yx[2*i+2]);
    mid   = int'(yx[2*i+1]);
    lo    = int'(yx[2*i]);
    digit = -2 * hi + mid + lo;
    s = (digit == 1) || (digit == -1);
    d = (digit == 2) || (digit == -2);
    return {s, d, yx[2*i+2]};
  endfunction

  function automatic logic [N-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return {1'b1, {(N-1){1'b0}}};
      1:       return {1'b0, {(N-1){1'b1}}};
      2:       return {N{1'b1}};
      3:       return '0;
      default: return N'($urandom);
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Issues one operation and follows it through BUSY, checking window
  // encodings and the exact latency; returns at the first DONE cycle.
  task automatic start_op(input logic [N-1:0] x, input logic [N-1:0] y,
                          input int gap, input bit noise);
    int waited;
    waited = 0;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    repeat (gap) tick();
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    check("accept_in_ready", in_ready, 1);
    a = x;
    b = y;
    in_valid = 1'b1;
    tick();
    exp_q.push_back(model_product(x, y));
    in_valid = 1'b0;
    a = N'($urandom);
    b = N'($urandom);
    for (int i = 0; i < ITER; i++) begin
      check("busy_in_ready", in_ready, 0);
      check("busy_out_valid", out_valid, 0);
      check("busy_window", {booth_s, booth_d, booth_n}, model_window(y, i));
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        a = N'($urandom);
        b = N'($urandom);
      end
      tick();
    end
    check("done_out_valid", out_valid, 1);
    check("done_window_idle", {booth_s, booth_d, booth_n}, 0);
  endtask

  // Stalls the consumer for 'hold' cycles, then completes the handshake.
  task automatic finish_op(input int hold, input bit noise);
    logic [PW-1:0] exp;
    check("scoreboard_nonempty", exp_q.size() > 0, 1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check("product", product, exp);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        a = N'($urandom);
        b = N'($urandom);
      end
      tick();
      check("stall_out_valid", out_valid, 1);
      check("stall_product", product, exp);
      check("stall_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_hs_out_valid", out_valid, 0);
    check("post_hs_in_ready", in_ready, 1);
    check("post_hs_product", product, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) tick();
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_product", product, 0);
    check("reset_booth", {booth_s, booth_d, booth_n}, 0);
    reset = 1'b0;
    tick();

    // Small positive operands.
    start_op(N'(3), N'(5), 0, 1'b0);
    finish_op(0, 1'b0);

    // Most negative squared: exact 2^(2N-2).
    start_op({1'b1, {(N-1){1'b0}}}, {1'b1, {(N-1){1'b0}}}, 0, 1'b0);
    finish_op(0, 1'b0);

    // Largest positive times most negative.
    start_op({1'b0, {(N-1){1'b1}}}, {1'b1, {(N-1){1'b0}}}, 1, 1'b0);
    finish_op(0, 1'b0);

    // -1 * -1: upper windows are 111 and add nothing.
    start_op({N{1'b1}}, {N{1'b1}}, 0, 1'b0);
    finish_op(0, 1'b0);

    // Consumer stall for three cycles with stray in_valid pulses.
    start_op(N'(-13), N'(11), 0, 1'b1);
    finish_op(3, 1'b1);

    // Reset during the second BUSY cycle discards the operation.
    while (!in_ready) tick();
    a = N'(7);
    b = N'(9);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midbusy_rst_in_ready", in_ready, 1);
    check("midbusy_rst_out_valid", out_valid, 0);
    check("midbusy_rst_booth", {booth_s, booth_d, booth_n}, 0);
    check("midbusy_rst_product", product, 0);
    start_op(N'(-5), N'(6), 0, 1'b0);
    finish_op(0, 1'b0);

    // Reset in DONE wins over a simultaneous handshake.
    start_op(N'(85), N'(51), 0, 1'b0);
    void'(exp_q.pop_front());
    reset     = 1'b1;
    out_ready = 1'b1;
    tick();
    reset     = 1'b0;
    out_ready = 1'b0;
    check("done_rst_out_valid", out_valid, 0);
    check("done_rst_in_ready", in_ready, 1);
    check("done_rst_product", product, 0);

    // Randomized operands, gaps, stalls and ignored in_valid noise.
    for (int k = 0; k < N_RANDOM; k++) begin
      start_op(pick_operand(), pick_operand(), $urandom_range(0, 2), 1'b1);
      finish_op($urandom_range(0, 2), 1'b1);
    end
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
